// File: rtl/chunked_addsub.sv
// rtl/chunked_addsub.sv - multi-cycle chunked adder/subtractor, one CHUNK-bit slice per cycle
// Optional saturating SUB_SAT mode (op 11) is built when ADDSUB_SAT_EN is defined.
module chunked_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_CLAMP = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, r_acc;
    logic [1:0]       op_q;
    logic             carry, a_msb, b_msb;
    logic [CW-1:0]    idx;

    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] raw, fin_r;
    logic             raw_ovf, borrow, fin_cout, fin_ovf;

    assign in_ready = (state == IDLE);

    always_comb begin
        sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        // Result slices enter at the top and shift down, so after N cycles r_acc is aligned.
        raw      = (r_acc >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        raw_ovf  = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);
        borrow   = ~sum[CHUNK];
        fin_r    = raw;
        fin_cout = (op_q == OP_ADD) ? sum[CHUNK] : borrow;
        fin_ovf  = raw_ovf;
        if (op_q == OP_CLAMP) begin
            fin_ovf = 1'b0;
            if (borrow)
                fin_r = '0;
        end
`ifdef ADDSUB_SAT_EN
        if (op_q == 2'b11 && raw_ovf)
            fin_r = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            r_acc     <= '0;
            op_q      <= OP_ADD;
            carry     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            r         <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert b once here and seed carry with 1.
                        a_q   <= a;
                        b_q   <= (op == OP_ADD) ? b : ~b;
                        carry <= (op == OP_ADD) ? cin : 1'b1;
                        a_msb <= a[WIDTH-1];
                        b_msb <= (op == OP_ADD) ? b[WIDTH-1] : ~b[WIDTH-1];
                        op_q  <= op;
                        r_acc <= '0;
                        idx   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    r_acc <= raw;
                    carry <= sum[CHUNK];
                    idx   <= idx + 1'b1;
                    if (idx == CW'(N - 1)) begin
                        r         <= fin_r;
                        cout      <= fin_cout;
                        zero      <= (fin_r == '0);
                        ovf       <= fin_ovf;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
